eth_tx_arbiter: RTL and testbench
=================================

Name: eth_tx_arbiter

Overview:
- Shares the single Ethernet TX path among NUM_REQ packet buffers (e.g. several async-FIFO transmit queues).
- Grants one requester at a time using round-robin order.
- Streams the granted requester's bytes to the transmit path with a valid/ready handshake.
- Truncates oversize frames, enforces an inter-frame gap, and pulses a per-requester "packet transmitted" strobe so each buffer can decrement its queued-packet counter.

Parameters:
- NUM_REQ, 4, number of requesters (minimum 2).
- MAX_LEN, 1518, maximum bytes forwarded per frame; longer frames are truncated.
- IFG_CYCLES, 12, idle cycles inserted after every frame before the next grant.

Ports:
- eth_tx_clk  in  1  TX clock; all logic is in this domain.
- eth_rst  in  1  asynchronous, active-high reset.
- req_pct_qued  in  NUM_REQ  level: requester i holds at least one complete packet.
- req_data  in  NUM_REQ*8  byte lanes; requester i occupies [8i+7:8i].
- req_valid  in  NUM_REQ  byte valid per requester.
- req_last  in  NUM_REQ  final byte of the packet per requester.
- req_ready  out  NUM_REQ  byte accepted from requester i.
- tx_data  out  8  byte to the transmit path.
- tx_valid  out  1  tx_data valid.
- tx_last  out  1  final byte of the frame.
- tx_ready  in  1  transmit path accepts the byte.
- grant  out  NUM_REQ  one-hot current owner; all zero when there is no owner.
- busy  out  1  high in every state except IDLE.
- pct_txed  out  NUM_REQ  one-cycle pulse: requester i's packet fully consumed.
- oversize  out  1  one-cycle pulse: the current frame was truncated at MAX_LEN.

Behaviour:
- Reset (async, any state, including mid-frame):
  - state=IDLE; grant=0; busy=0; pct_txed=0; oversize=0; byte count=0; IFG count=0.
  - RR pointer=NUM_REQ-1, so requester 0 wins first.
  - tx_valid, tx_last and req_ready decode to 0.
  - A frame cut by reset is abandoned; no pct_txed pulse is issued for it.
- Byte count width is $clog2(MAX_LEN+1). A byte is counted on each tx_valid&tx_ready handshake in XFER.
- IDLE:
  - If any req_pct_qued bit is set, select the first set bit searching from pointer+1 with wrap-around.
  - Register grant (one-hot) and pointer=winner; enter XFER next cycle.
  - Latency: req_pct_qued high in cycle N gives grant in N+1 and first byte possible in N+1.
- XFER (winner g):
  - Pass-through paths: tx_data=req_data[g]; tx_valid=req_valid[g]; req_ready[g]=tx_ready; all other req_ready bits=0.
  - tx_last=req_last[g] OR (count==MAX_LEN-1).
  - On a handshake with req_last[g]: grant<=0; pct_txed[g] pulses next cycle; go to IFG.
  - On a handshake at count==MAX_LEN-1 without req_last: tx_last=1; grant is kept; oversize pulses next cycle; go to DRAIN.
  - When req_last and MAX_LEN coincide on the same byte, treat it as a normal end: no oversize.
  - Deassertion of req_pct_qued during XFER is ignored. The frame ends only on req_last or truncation.
- DRAIN:
  - tx_valid=0; req_ready[g]=1, so bytes are discarded.
  - On req_valid[g]&req_last[g]: grant<=0; pct_txed[g] pulses next cycle; go to IFG.
- IFG:
  - tx_valid=0; all req_ready bits=0.
  - Count IFG_CYCLES cycles, then go to IDLE.
  - Total gap from tx_last handshake to next grant = IFG_CYCLES+1 cycles (includes the IDLE arbitration cycle).
  - Requests arriving during IFG wait and are arbitrated in IDLE.
- Fairness: the pointer updates only on grant. A requester that keeps req_pct_qued high cannot win twice in a row while another requester is pending.
- Back-pressure: while tx_ready=0, no byte is consumed, count holds, and req_ready[g]=0.
- pct_txed is registered, one cycle wide, and at most one bit is set at a time.

Test Plan:
- Single requester: req_pct_qued[1]=1, 64-byte packet with tx_ready=1.
  - grant=4'b0010 one cycle later; 64 bytes out in order; tx_last on byte 64.
  - pct_txed=4'b0010 pulse; next grant no earlier than 13 cycles after tx_last.
- Round-robin: requesters 0, 2 and 3 all request continuously, each sending 10-byte packets.
  - Grant order is 0, 2, 3, 0, 2, 3.
  - No requester is granted twice consecutively.
- Back-pressure: random tx_ready duty of 50% on a 100-byte packet.
  - Output byte sequence identical to input.
  - Exactly 100 handshakes; req_ready mirrors tx_ready only for the granted lane.
- Truncation (MAX_LEN=64 build): 80-byte packet.
  - 64 bytes forwarded with tx_last on byte 64; oversize pulses once.
  - Remaining 16 bytes are drained with tx_valid=0; pct_txed pulses after byte 80.
- Boundary: 64-byte packet with MAX_LEN=64.
  - tx_last on byte 64; oversize=0; no DRAIN state entered.
- Reset mid-frame: assert eth_rst at byte 20 of requester 2's frame, then release.
  - grant, busy, tx_valid, pct_txed and oversize are 0 immediately (asynchronously).
  - With requesters 0 and 2 pending, the next grant goes to requester 0.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter
// Round-robin arbiter that shares one Ethernet TX byte stream among NUM_REQ
// packet buffers. Frames are passed through byte by byte with valid/ready.
// Frames longer than MAX_LEN are cut, and the rest of the frame is drained.
// An inter-frame gap follows every frame, and each buffer gets a one-cycle
// "packet transmitted" strobe.
module eth_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int MAX_LEN    = 1518,
    parameter int IFG_CYCLES = 12
) (
    input  logic                 eth_tx_clk,
    input  logic                 eth_rst,
    input  logic [NUM_REQ-1:0]   req_pct_qued,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    output logic                 tx_last,
    input  logic                 tx_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic [NUM_REQ-1:0]   pct_txed,
    output logic                 oversize
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam int IFG_W = $clog2(IFG_CYCLES + 1);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN,
        IFG
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [NUM_REQ-1:0] r_grant;
    logic [IDX_W-1:0]   r_grantIdx;
    logic [IDX_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_byteCount;
    logic [IFG_W-1:0]   r_ifgCount;
    logic [NUM_REQ-1:0] r_pctTxed;
    logic               r_oversize;

    logic               w_found;
    logic [IDX_W-1:0]   w_winner;
    logic [NUM_REQ-1:0] w_winnerOneHot;
    logic [7:0]         w_selData;
    logic               w_selValid;
    logic               w_selLast;
    logic               w_atMax;
    logic               w_handshake;
    logic               w_frameDone;
    logic               w_truncate;

    // The owner's byte lane. The result is used only while in XFER or DRAIN.
    assign w_selData  = req_data[8*r_grantIdx +: 8];
    assign w_selValid = req_valid[r_grantIdx];
    assign w_selLast  = req_last[r_grantIdx];

    assign w_atMax     = (r_byteCount == CNT_W'(MAX_LEN - 1));
    assign w_handshake = (r_state == XFER) && w_selValid && tx_ready;
    // A frame ends on its own last byte. That byte can come in XFER, or after truncation in DRAIN.
    assign w_frameDone = (w_handshake && w_selLast) ||
                         ((r_state == DRAIN) && w_selValid && w_selLast);
    assign w_truncate  = w_handshake && w_atMax && !w_selLast;

    assign w_winnerOneHot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;

    assign grant    = r_grant;
    assign busy     = (r_state != IDLE);
    assign pct_txed = r_pctTxed;
    assign oversize = r_oversize;

    // Round-robin search: the first pending requester after the last winner, with wrap-around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!w_found && req_pct_qued[IDX_W'((int'(r_ptr) + off) % NUM_REQ)]) begin
                w_found  = 1'b1;
                w_winner = IDX_W'((int'(r_ptr) + off) % NUM_REQ);
            end
        end
    end

    // FSM next state and the datapath steering decoded from the current state.
    always_comb begin
        w_nextState = r_state;
        tx_data     = 8'h00;
        tx_valid    = 1'b0;
        tx_last     = 1'b0;
        req_ready   = '0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_nextState = XFER;
                end
            end
            XFER: begin
                tx_data               = w_selData;
                tx_valid              = w_selValid;
                tx_last               = w_selLast || w_atMax;
                req_ready[r_grantIdx] = tx_ready;
                if (w_handshake && w_selLast) begin
                    w_nextState = IFG;
                end else if (w_truncate) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                req_ready[r_grantIdx] = 1'b1;
                if (w_frameDone) begin
                    w_nextState = IFG;
                end
            end
            IFG: begin
                if (r_ifgCount == IFG_W'(IFG_CYCLES - 1)) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge eth_tx_clk or posedge eth_rst) begin
        if (eth_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Grant ownership. The pointer moves only when a grant is issued, which keeps the arbitration fair.
    always_ff @(posedge eth_tx_clk or posedge eth_rst) begin
        if (eth_rst) begin
            r_grant    <= '0;
            r_grantIdx <= '0;
            r_ptr      <= IDX_W'(NUM_REQ - 1);
        end else if ((r_state == IDLE) && w_found) begin
            r_grant    <= w_winnerOneHot;
            r_grantIdx <= w_winner;
            r_ptr      <= w_winner;
        end else if (w_frameDone) begin
            r_grant    <= '0;
        end
    end

    // Bytes forwarded in the current frame. Only an accepted byte advances the count.
    always_ff @(posedge eth_tx_clk or posedge eth_rst) begin
        if (eth_rst) begin
            r_byteCount <= '0;
        end else if (r_state != XFER) begin
            r_byteCount <= '0;
        end else if (w_handshake) begin
            r_byteCount <= (w_frameDone || w_truncate) ? '0 : r_byteCount + CNT_W'(1);
        end
    end

    // Inter-frame gap timer. It counts only while in IFG and is cleared on the way out.
    always_ff @(posedge eth_tx_clk or posedge eth_rst) begin
        if (eth_rst) begin
            r_ifgCount <= '0;
        end else if ((r_state == IFG) && (w_nextState == IFG)) begin
            r_ifgCount <= r_ifgCount + IFG_W'(1);
        end else begin
            r_ifgCount <= '0;
        end
    end

    // One-cycle strobes: end-of-packet to the owning buffer, and truncation notice.
    always_ff @(posedge eth_tx_clk or posedge eth_rst) begin
        if (eth_rst) begin
            r_pctTxed  <= '0;
            r_oversize <= 1'b0;
        end else begin
            r_pctTxed  <= w_frameDone ? r_grant : '0;
            r_oversize <= w_truncate;
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter
// Randomized scoreboard bench for eth_tx_arbiter, built with MAX_LEN=64.
// A frame-level reference model predicts the grant order and the bytes
// forwarded for each frame. A free-running monitor checks what the DUT emits.
module tb_eth_tx_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int MAX_LEN    = 64;
    localparam int IFG_CYCLES = 12;

    typedef struct {
        int req;
        int fwdLen;
        bit over;
        bit chkGap;
    } frame_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   reqPctQued;
    logic [NUM_REQ*8-1:0] reqData;
    logic [NUM_REQ-1:0]   reqValid;
    logic [NUM_REQ-1:0]   reqLast;
    logic [NUM_REQ-1:0]   reqReady;
    logic [7:0]           txData;
    logic                 txValid;
    logic                 txLast;
    logic                 txReady;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic [NUM_REQ-1:0]   pctTxed;
    logic                 oversize;

    int errCount   = 0;
    int checkCount = 0;
    int cycleCount = 0;
    int readyPct   = 100;
    int validPct   = 100;

    logic [7:0] laneBytes[NUM_REQ][$];
    bit         laneLast[NUM_REQ][$];
    int         modelLen[NUM_REQ][$];
    logic [7:0] modelBytes[NUM_REQ][$];
    int         modelPtr = NUM_REQ - 1;
    frame_t     expFrames[$];
    logic [7:0] expTx[$];

    frame_t cur;
    bit     curActive = 1'b0;
    int     hsCnt, dataErr, lastCnt, lastIdx, overCnt;
    int     lastHsCycle, pctCycle, reqRiseCycle;
    int     laneErr = 0;
    logic [NUM_REQ-1:0] prevGrant = '0;
    logic [NUM_REQ-1:0] prevQued  = '0;
    logic [NUM_REQ-1:0] accepted;

    eth_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .MAX_LEN(MAX_LEN),
        .IFG_CYCLES(IFG_CYCLES)
    ) dut (
        .eth_tx_clk  (clk),
        .eth_rst     (rst),
        .req_pct_qued(reqPctQued),
        .req_data    (reqData),
        .req_valid   (reqValid),
        .req_last    (reqLast),
        .req_ready   (reqReady),
        .tx_data     (txData),
        .tx_valid    (txValid),
        .tx_last     (txLast),
        .tx_ready    (txReady),
        .grant       (grant),
        .busy        (busy),
        .pct_txed    (pctTxed),
        .oversize    (oversize)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    // Queue one packet on a lane. The driver and the reference model each get a copy of the bytes.
    task automatic applyStimulus(input int lane, input int len);
        logic [7:0] b;
        for (int k = 0; k < len; k++) begin
            b = 8'($urandom_range(0, 255));
            laneBytes[lane].push_back(b);
            laneLast[lane].push_back(k == len - 1);
            modelBytes[lane].push_back(b);
        end
        modelLen[lane].push_back(len);
    endtask

    function automatic bit modelPending();
        bit any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (modelLen[i].size() != 0) any = 1'b1;
        end
        return any;
    endfunction

    function automatic bit lanesEmpty();
        bit empty = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (laneBytes[i].size() != 0) empty = 1'b0;
        end
        return empty;
    endfunction

    // Reference model. Serve queued packets in round-robin order, starting after the last winner.
    // Each frame forwards min(len, MAX_LEN) bytes and is flagged oversize when len > MAX_LEN.
    task automatic runModel();
        bit         first = 1'b1;
        int         w;
        int         len;
        frame_t     f;
        logic [7:0] b;
        while (modelPending()) begin
            w = -1;
            for (int off = 1; off <= NUM_REQ; off++) begin
                if (w < 0 && modelLen[(modelPtr + off) % NUM_REQ].size() != 0) w = (modelPtr + off) % NUM_REQ;
            end
            len      = modelLen[w].pop_front();
            f.req    = w;
            f.fwdLen = (len > MAX_LEN) ? MAX_LEN : len;
            f.over   = (len > MAX_LEN);
            f.chkGap = !first;
            first    = 1'b0;
            for (int k = 0; k < len; k++) begin
                b = modelBytes[w].pop_front();
                if (k < f.fwdLen) expTx.push_back(b);
            end
            expFrames.push_back(f);
            modelPtr = w;
        end
    endtask

    task automatic clearBench();
        for (int i = 0; i < NUM_REQ; i++) begin
            laneBytes[i].delete();
            laneLast[i].delete();
            modelLen[i].delete();
            modelBytes[i].delete();
        end
        expFrames.delete();
        expTx.delete();
        curActive = 1'b0;
        modelPtr  = NUM_REQ - 1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_grant"}, int'(grant), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_tx_valid"}, int'(txValid), 0);
        checkOutput({tag, "_tx_last"}, int'(txLast), 0);
        checkOutput({tag, "_req_ready"}, int'(reqReady), 0);
        checkOutput({tag, "_pct_txed"}, int'(pctTxed), 0);
        checkOutput({tag, "_oversize"}, int'(oversize), 0);
    endtask

    // Wait until every predicted frame has been observed and the arbiter is idle again.
    task automatic waitPhaseDone(input string tag);
        int n    = 0;
        bit done = 1'b0;
        while (!done && n < 6000) begin
            @(negedge clk);
            n++;
            done = (expFrames.size() == 0) && !curActive && !busy && lanesEmpty();
        end
        checkOutput({tag, "_complete"}, int'(done), 1);
        checkOutput({tag, "_lane_rules"}, laneErr, 0);
        laneErr = 0;
        if (!done) begin
            rst = 1'b1;
            clearBench();
            repeat (2) @(negedge clk);
            rst = 1'b0;
        end
    endtask

    // Start a frame, reset the DUT part-way through it, then check how the arbiter restarts.
    task automatic resetMidFrame(input int lane, input int atByte, input int len);
        int n = 0;
        readyPct = 100;
        validPct = 100;
        applyStimulus(lane, len);
        runModel();
        while (!(curActive && cur.req == lane && hsCnt >= atByte) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reset_reached_byte", int'(curActive && hsCnt >= atByte), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs("reset_mid");
        clearBench();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        applyStimulus(2, 12);
        applyStimulus(0, 12);
        runModel();
        waitPhaseDone("after_reset");
    endtask

    // Lane drivers. Accepted bytes are taken at the negedge and popped after the posedge; new values are then driven.
    initial begin
        reqPctQued = '0;
        reqValid   = '0;
        reqLast    = '0;
        reqData    = '0;
        txReady    = 1'b0;
        forever begin
            @(negedge clk);
            accepted = reqValid & reqReady;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accepted[i] && laneBytes[i].size() != 0) begin
                    void'(laneBytes[i].pop_front());
                    void'(laneLast[i].pop_front());
                end
                if (laneBytes[i].size() != 0) begin
                    reqPctQued[i]      = 1'b1;
                    reqValid[i]        = (int'($urandom_range(0, 99)) < validPct);
                    reqData[8*i +: 8]  = laneBytes[i][0];
                    reqLast[i]         = laneLast[i][0];
                end else begin
                    reqPctQued[i]      = 1'b0;
                    reqValid[i]        = 1'b0;
                    reqData[8*i +: 8]  = 8'h00;
                    reqLast[i]         = 1'b0;
                end
            end
            txReady = (int'($urandom_range(0, 99)) < readyPct);
        end
    end

    // Monitor: pops expected frames on each new grant and checks bytes, tx_last, strobes and timing.
    initial begin
        logic [7:0] expByte;
        forever begin
            @(negedge clk);
            cycleCount++;
            if (rst) begin
                prevGrant = '0;
                prevQued  = '0;
            end else begin
                if (reqPctQued != 0 && prevQued == 0) reqRiseCycle = cycleCount;
                if (grant != 0 && prevGrant == 0) begin
                    if (expFrames.size() == 0 || curActive) begin
                        checkOutput("unexpected_grant", int'(grant), 0);
                    end else begin
                        cur       = expFrames.pop_front();
                        curActive = 1'b1;
                        hsCnt     = 0;
                        dataErr   = 0;
                        lastCnt   = 0;
                        lastIdx   = -1;
                        overCnt   = 0;
                        checkOutput("grant_onehot", int'(grant), 1 << cur.req);
                        if (cur.chkGap) checkOutput("ifg_gap", cycleCount - pctCycle, IFG_CYCLES + 1);
                        else checkOutput("grant_latency", cycleCount - reqRiseCycle, 1);
                    end
                end
                if (txValid && txReady) begin
                    if (!curActive) begin
                        laneErr++;
                    end else begin
                        hsCnt++;
                        expByte = (expTx.size() != 0) ? expTx.pop_front() : 8'hxx;
                        if (txData !== expByte) dataErr++;
                        if (txLast) begin
                            lastCnt++;
                            lastIdx     = hsCnt;
                            lastHsCycle = cycleCount;
                        end
                    end
                end
                if ((reqReady & ~grant) != 0) laneErr++;
                if (txValid && grant == 0) laneErr++;
                if (txValid && reqReady != (txReady ? grant : '0)) laneErr++;
                if (oversize) begin
                    if (curActive) overCnt++;
                    else laneErr++;
                end
                if (pctTxed != 0) begin
                    pctCycle = cycleCount;
                    if (!curActive) begin
                        checkOutput("unexpected_pct", int'(pctTxed), 0);
                    end else begin
                        checkOutput("pct_txed", int'(pctTxed), 1 << cur.req);
                        checkOutput("fwd_count", hsCnt, cur.fwdLen);
                        checkOutput("data_errors", dataErr, 0);
                        checkOutput("tx_last_pos", (lastCnt == 1) ? lastIdx : -1, cur.fwdLen);
                        checkOutput("oversize_pulses", overCnt, int'(cur.over));
                        if (!cur.over) checkOutput("no_drain", cycleCount - lastHsCycle, 1);
                        curActive = 1'b0;
                    end
                end
                prevGrant = grant;
                prevQued  = reqPctQued;
            end
        end
    end

    // Test sequence.
    initial begin
        int nPkts;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkResetOutputs("por");
        rst = 1'b0;

        $display("[TB] round-robin 0/2/3");
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 10);
            applyStimulus(2, 10);
            applyStimulus(3, 10);
        end
        runModel();
        waitPhaseDone("rr");

        $display("[TB] single requester, 64 bytes (= MAX_LEN)");
        applyStimulus(1, 64);
        runModel();
        waitPhaseDone("single");

        $display("[TB] truncation, 80 bytes");
        applyStimulus(3, 80);
        runModel();
        waitPhaseDone("trunc");

        $display("[TB] back-pressure");
        readyPct = 50;
        applyStimulus(2, 60);
        runModel();
        waitPhaseDone("bp60");
        applyStimulus(0, 100);
        runModel();
        waitPhaseDone("bp100");

        $display("[TB] random phases");
        for (int p = 0; p < 4; p++) begin
            readyPct = int'($urandom_range(30, 100));
            validPct = int'($urandom_range(50, 100));
            nPkts    = int'($urandom_range(1, 4));
            for (int k = 0; k < nPkts; k++) begin
                applyStimulus(int'($urandom_range(0, NUM_REQ - 1)), int'($urandom_range(1, 90)));
            end
            runModel();
            waitPhaseDone("random");
        end

        $display("[TB] reset mid-frame");
        resetMidFrame(2, 20, 40);
        resetMidFrame(1, 5, 30);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

    // Watchdog against a hung run.
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
